// File: rtl/intr_ctrl_pkg.sv
// Shared system package: interrupt controller state encoding and default device register map.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_REQ     = 2'd1,
    IC_SERVICE = 2'd2
  } ic_state_e;

  localparam logic [31:0] IC_IEADDR  = 32'hF000_0020;
  localparam logic [31:0] IC_IPADDR  = 32'hF000_0024;
  localparam logic [31:0] IC_VECADDR = 32'hF000_0028;
  localparam logic [31:0] IC_OVFADDR = 32'hF000_002C;

  // Index width for an n-entry source vector; never narrower than one bit.
  function automatic int ic_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index priority encoder: returns the index of the least significant set bit.
module prio_enc #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] mask_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Scan high to low so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: per-source pending/overflow latching, enable mask,
// single-level request/acknowledge/EOI handshake with the CPU.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int               DBITS   = 32,
  parameter int               NSRC    = 4,
  parameter logic [DBITS-1:0] IEADDR  = DBITS'(IC_IEADDR),
  parameter logic [DBITS-1:0] IPADDR  = DBITS'(IC_IPADDR),
  parameter logic [DBITS-1:0] VECADDR = DBITS'(IC_VECADDR),
  parameter logic [DBITS-1:0] OVFADDR = DBITS'(IC_OVFADDR)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DBITS-1:0] ABUS,
  inout  wire  [DBITS-1:0] DBUS,
  input  logic             WE,
  input  logic [NSRC-1:0]  SRC,
  input  logic             IACK,
  output logic             IRQ
);

  localparam int VW = ic_idx_w(NSRC);

  ic_state_e       state_q, state_d;
  logic [NSRC-1:0] ie_q, ie_d;
  logic [NSRC-1:0] ip_q, ip_d;
  logic [NSRC-1:0] ovf_q, ovf_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            irq_q;

  logic sel_ie, sel_ip, sel_vec, sel_ovf, sel_any;
  logic wr_ie, wr_ip, wr_vec, wr_ovf;
  logic rd_en;
  logic [DBITS-1:0] wdata, rdata;
  logic             unused_wdata;

  logic [NSRC-1:0] pend, ack_mask;
  logic [VW-1:0]   pidx;
  logic            pany, ack;

  assign sel_ie  = (ABUS == IEADDR);
  assign sel_ip  = (ABUS == IPADDR);
  assign sel_vec = (ABUS == VECADDR);
  assign sel_ovf = (ABUS == OVFADDR);
  assign sel_any = sel_ie | sel_ip | sel_vec | sel_ovf;

  assign wr_ie  = WE & sel_ie;
  assign wr_ip  = WE & sel_ip;
  assign wr_vec = WE & sel_vec;
  assign wr_ovf = WE & sel_ovf;

  assign wdata        = DBUS;
  assign unused_wdata = ^wdata;

  assign pend = ip_q & ie_q;

  prio_enc #(.N(NSRC), .W(VW)) u_prio (
    .mask_i (pend),
    .idx_o  (pidx),
    .any_o  (pany)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ack     = 1'b0;
    case (state_q)
      IC_IDLE:    if (pany) state_d = IC_REQ;
      // Losing the pending source (cleared or masked) withdraws the request before IACK counts.
      IC_REQ: begin
        if (!pany) begin
          state_d = IC_IDLE;
        end else if (IACK) begin
          ack     = 1'b1;
          vec_d   = pidx;
          state_d = IC_SERVICE;
        end
      end
      IC_SERVICE: if (wr_vec) state_d = IC_IDLE;
      default:    state_d = IC_IDLE;
    endcase
  end

  assign ack_mask = ack ? (NSRC'(1) << pidx) : '0;

  // New events win over any same-cycle clear; an event on an already-pending bit is an overflow.
  always_comb begin
    ie_d  = wr_ie ? wdata[NSRC-1:0] : ie_q;
    ip_d  = (ip_q & ~((wr_ip ? wdata[NSRC-1:0] : '0) | ack_mask)) | SRC;
    ovf_d = (ovf_q & ~(wr_ovf ? wdata[NSRC-1:0] : '0)) | (SRC & ip_q);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IC_IDLE;
      ie_q    <= '0;
      ip_q    <= '0;
      ovf_q   <= '0;
      vec_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      ip_q    <= ip_d;
      ovf_q   <= ovf_d;
      vec_q   <= vec_d;
      irq_q   <= (state_d == IC_REQ);
    end
  end

  assign IRQ = irq_q;

  always_comb begin
    rdata = '0;
    if (sel_ie) begin
      rdata[NSRC-1:0] = ie_q;
    end else if (sel_ip) begin
      rdata[NSRC-1:0] = ip_q;
    end else if (sel_ovf) begin
      rdata[NSRC-1:0] = ovf_q;
    end else if (sel_vec) begin
      rdata[VW-1:0]    = vec_q;
      rdata[DBITS-1]   = (state_q == IC_SERVICE);
    end
  end

  assign rd_en = ~WE & sel_any;
  assign DBUS  = rd_en ? rdata : {DBITS{1'bz}};

endmodule
